// File: rtl/memoria_dados.sv
// Data memory: 256 x 8, single port, synchronous write and registered read.
// Define MEMDADOS_BYPASS_EN for write-first forwarding on same-address read/write.
module memoria_dados #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Endereco,
    input  logic [DATA_WIDTH-1:0] DadoEscr,
    output logic [DATA_WIDTH-1:0] DadoLido,
    input  logic                  MenWrite,
    input  logic                  MenRead
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    // Single port, so a concurrent read and write always target the same word.
    always_comb begin
        rd_word = mem[Endereco];
`ifdef MEMDADOS_BYPASS_EN
        if (MenWrite) begin
            rd_word = DadoEscr;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            DadoLido <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (MenWrite) begin
                mem[Endereco] <= DadoEscr;
            end
            if (MenRead) begin
                DadoLido <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_memoria_dados.sv
// Scoreboard bench for memoria_dados: stimulus pushes expected read data,
// a monitor pops and compares after each read edge and checks hold otherwise.
module tb_memoria_dados;

    logic       Clock;
    logic       Reset;
    logic [7:0] Endereco;
    logic [7:0] DadoEscr;
    logic [7:0] DadoLido;
    logic       MenWrite;
    logic       MenRead;

    memoria_dados #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Endereco (Endereco),
        .DadoEscr (DadoEscr),
        .DadoLido (DadoLido),
        .MenWrite (MenWrite),
        .MenRead  (MenRead)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [7:0] expq [$];
    int         total  = 0;
    int         passed = 0;
    logic [7:0] last_exp;
    logic       armed = 1'b0;
    logic       s_rst;
    logic       s_rd;
    logic [7:0] exp_v;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Monitor: samples controls at the edge, compares 1 time unit later.
    always @(posedge Clock) begin
        s_rst = Reset;
        s_rd  = MenRead;
        #1;
        if (s_rst) begin
            check("reset_out", DadoLido, 8'h00);
            last_exp = 8'h00;
            armed    = 1'b1;
        end else if (s_rd) begin
            if (expq.size() == 0) begin
                check("unexpected_read", DadoLido, 8'hxx);
            end else begin
                exp_v = expq.pop_front();
                check("read", DadoLido, exp_v);
                last_exp = exp_v;
            end
        end else if (armed) begin
            check("hold", DadoLido, last_exp);
        end
    end

    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [7:0] a, input logic [7:0] d);
        @(negedge Clock);
        Reset    = r;
        MenWrite = w;
        MenRead  = rd;
        Endereco = a;
        DadoEscr = d;
        @(posedge Clock);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp);
        expq.push_back(exp);
        cyc(1'b0, 1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b0;
        MenWrite = 1'b0;
        MenRead  = 1'b0;
        Endereco = 8'h00;
        DadoEscr = 8'h00;
        repeat (2) @(posedge Clock);

        // 1: reset then reads of cleared memory
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        rd(8'h00, 8'h00);
        rd(8'h7F, 8'h00);
        rd(8'hFF, 8'h00);

        // 2: mem[i] = i across the full range
        for (int i = 0; i < 256; i++) wr(8'(i), 8'(i));
        for (int i = 0; i < 256; i++) rd(8'(i), 8'(i));

        // 3: hold while MenRead=0
        wr(8'h10, 8'hA5);
        rd(8'h11, 8'h11);
        idle();
        idle();
        rd(8'h12, 8'h12);
        wr(8'h13, 8'h99);
        idle();
        rd(8'h10, 8'hA5);
        rd(8'h13, 8'h99);

        // 4: same-address read/write collision
        wr(8'h20, 8'h11);
`ifdef MEMDADOS_BYPASS_EN
        expq.push_back(8'h22);
`else
        expq.push_back(8'h11);
`endif
        cyc(1'b0, 1'b1, 1'b1, 8'h20, 8'h22);
        rd(8'h20, 8'h22);

        // 5: reset overrides a concurrent write and clears everything
        for (int i = 0; i < 256; i++) wr(8'(i), 8'(i) ^ 8'h3C);
        rd(8'h40, 8'h7C);
        cyc(1'b1, 1'b1, 1'b0, 8'h40, 8'h55);
        for (int i = 0; i < 256; i++) rd(8'(i), 8'h00);

        // 6: boundary addresses do not alias
        wr(8'hFF, 8'hFF);
        wr(8'h00, 8'h01);
        rd(8'hFF, 8'hFF);
        rd(8'h00, 8'h01);
        rd(8'h80, 8'h00);

        idle();
        idle();
        @(negedge Clock);
        total++;
        if (expq.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
